// File: rtl/reset_sequencer.sv
// Staggered per-stage reset generator: hold, ordered stage releases, then RUN with a saturating cycle count.
// Optional heartbeat watchdog is compiled in with `define WATCHDOG_EN.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int STAGE_GAP   = 4,
  parameter int WDOG_LIMIT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic                  heartbeat,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_done,
  output logic [31:0]           seq_count,
  output logic                  wdog_expired
);

  localparam int CMAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CMAX    = (CMAX_HG > WDOG_LIMIT) ? CMAX_HG : WDOG_LIMIT;
  localparam int CW      = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [NUM_STAGES-1:0] stage_nxt;
  logic                  done_nxt;
  logic [31:0]           count_nxt;
  logic                  soft_hit;

  assign soft_hit = (state == RUN) && soft_rst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      stage_rst <= '1;
      seq_done  <= 1'b0;
      seq_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stage_rst <= stage_nxt;
      seq_done  <= done_nxt;
      seq_count <= count_nxt;
    end
  end

  // Stages release by shifting zeros in from bit 0, so the order is monotonic by construction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stage_nxt = stage_rst;
    done_nxt  = seq_done;
    count_nxt = seq_count;
    case (state)
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          stage_nxt = stage_rst << 1;
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (stage_rst == '0) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
          count_nxt = '0;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          stage_nxt = stage_rst << 1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (soft_rst_req) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          stage_nxt = '1;
          done_nxt  = 1'b0;
          count_nxt = '0;
        end else if (seq_count != 32'hFFFF_FFFF) begin
          count_nxt = seq_count + 32'd1;
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
        stage_nxt = '1;
        done_nxt  = 1'b0;
        count_nxt = '0;
      end
    endcase
  end

`ifdef WATCHDOG_EN
  localparam logic [CW-1:0] WDOG_C = CW'(WDOG_LIMIT);

  logic [CW-1:0] wcnt, wcnt_nxt;
  logic          wdog_q, wdog_nxt;

  // Counter only runs in RUN; it saturates at the limit so the flag stays meaningful.
  always_comb begin
    wcnt_nxt = '0;
    wdog_nxt = wdog_q;
    if (soft_hit) begin
      wdog_nxt = 1'b0;
    end else if (state == RUN) begin
      if (!heartbeat) begin
        wcnt_nxt = (wcnt == WDOG_C) ? wcnt : wcnt + 1'b1;
        if (wcnt_nxt == WDOG_C) wdog_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt   <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt   <= wcnt_nxt;
      wdog_q <= wdog_nxt;
    end
  end

  assign wdog_expired = wdog_q;
`else
  logic unused_wdog;
  assign unused_wdog  = heartbeat ^ soft_hit;
  assign wdog_expired = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on vector table plus hand-written soft/hard reset,
// held-request, watchdog and saturation sequences.
module tb_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst, soft_rst_req, heartbeat;
  logic [2:0]  stage_rst;
  logic        seq_done, wdog_expired;
  logic [31:0] seq_count;

  int errors = 0;
  int checks = 0;

`ifdef WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  reset_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(2), .STAGE_GAP(4), .WDOG_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .heartbeat(heartbeat),
    .stage_rst(stage_rst), .seq_done(seq_done), .seq_count(seq_count),
    .wdog_expired(wdog_expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, s, h;
    logic [2:0]  stage;
    logic        done;
    logic [31:0] count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, h, input logic [2:0] st, input logic d, input logic [31:0] c);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.stage = st; v.done = d; v.count = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled there too.
  task automatic step(input logic r, s, h);
    rst = r; soft_rst_req = s; heartbeat = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic d, input logic [31:0] c);
    chk({tag, " stage_rst"}, 32'(stage_rst), 32'(st));
    chk({tag, " seq_done"},  32'(seq_done),  32'(d));
    chk({tag, " seq_count"}, seq_count, c);
  endtask

  initial begin
    rst = 1'b1; soft_rst_req = 1'b0; heartbeat = 1'b0;

    // Power-on: 5 reset cycles, then E0 = first edge with rst low (k = 0).
    for (int i = 0; i < 5; i++) add(1, 0, 0, 3'b111, 0, 0);
    add(0, 0, 0, 3'b111, 0, 0);                                 // k0
    add(0, 0, 0, 3'b111, 0, 0);                                 // k1
    for (int k = 2; k < 6; k++)  add(0, 0, 0, 3'b110, 0, 0);    // stage 0 out at E0+2
    for (int k = 6; k < 10; k++) add(0, 0, 0, 3'b100, 0, 0);    // stage 1 out at E0+6
    add(0, 0, 0, 3'b000, 0, 0);                                 // k10 stage 2 out
    for (int k = 11; k < 17; k++) add(0, 0, 0, 3'b000, 1, 32'(k - 11));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].h);
      chk_all($sformatf("v%0d", i), vecs[i].stage, vecs[i].done, vecs[i].count);
      chk($sformatf("v%0d wdog", i), 32'(wdog_expired), 32'd0);
    end

    // Watchdog: seq_done rose at E0+11, no heartbeat -> expiry at E0+19 when enabled.
    for (int k = 17; k < 23; k++) begin
      step(0, 0, 0);
      if (k == 18) chk("wdog before limit", 32'(wdog_expired), 32'd0);
      if (k == 19) chk("wdog at limit", 32'(wdog_expired), 32'(WD));
    end
    chk("wdog sticky", 32'(wdog_expired), 32'(WD));
    chk("count at E0+22", seq_count, 32'd11);

    // Soft reset at S, replay with E0 = S+1.
    step(0, 1, 0);
    chk_all("soft S", 3'b111, 0, 0);
    chk("soft S wdog", 32'(wdog_expired), 32'd0);
    for (int j = 1; j <= 12; j++) begin
      step(0, 0, (j % 5) == 0);
      if (j == 2)  chk_all("soft S+2", 3'b111, 0, 0);
      if (j == 3)  chk_all("soft S+3", 3'b110, 0, 0);
      if (j == 7)  chk_all("soft S+7", 3'b100, 0, 0);
      if (j == 11) chk_all("soft S+11", 3'b000, 0, 0);
      if (j == 12) chk_all("soft S+12", 3'b000, 1, 0);
    end
    // Heartbeat every 5 cycles keeps the watchdog quiet.
    for (int m = 1; m <= 20; m++) begin
      step(0, 0, (m % 5) == 0);
      chk($sformatf("hb m%0d wdog", m), 32'(wdog_expired), 32'd0);
    end
    chk("hb count", seq_count, 32'd20);

    // rst while in RUN overrides a simultaneous soft request.
    step(1, 1, 1);
    chk_all("rst in RUN", 3'b111, 0, 0);
    chk("rst in RUN wdog", 32'(wdog_expired), 32'd0);

    // rst reasserted mid-RELEASE at E0+7.
    step(1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0);
      if (k == 1) chk_all("mid k1", 3'b111, 0, 0);
      if (k == 2) chk_all("mid k2", 3'b110, 0, 0);
      if (k == 6) chk_all("mid k6", 3'b100, 0, 0);
    end
    step(1, 0, 0);
    chk_all("mid rst E0+7", 3'b111, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 1);
      if (k == 1)  chk_all("replay k1", 3'b111, 0, 0);
      if (k == 2)  chk_all("replay k2", 3'b110, 0, 0);
      if (k == 10) chk_all("replay k10", 3'b000, 0, 0);
      if (k == 11) chk_all("replay k11", 3'b000, 1, 0);
    end

    // soft_rst_req held high E0..E0+20: RUN at E0+11, retrigger on first RUN edge E0+12.
    step(1, 0, 0);
    for (int k = 0; k <= 25; k++) begin
      step(0, k <= 20, 1);
      if (k == 10) chk_all("held k10", 3'b000, 0, 0);
      if (k == 11) chk_all("held k11", 3'b000, 1, 0);
      if (k == 12) chk_all("held k12", 3'b111, 0, 0);
      if (k == 14) chk_all("held k14", 3'b111, 0, 0);
      if (k == 15) chk_all("held k15", 3'b110, 0, 0);
      if (k == 23) chk_all("held k23", 3'b000, 0, 0);
      if (k == 24) chk_all("held k24", 3'b000, 1, 0);
      if (k == 25) chk_all("held k25", 3'b000, 1, 1);
    end

    // Saturation.
    force dut.seq_count = 32'hFFFF_FFFE;
    #1;
    release dut.seq_count;
    step(0, 0, 1);
    chk("sat +1", seq_count, 32'hFFFF_FFFF);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("sat +3", seq_count, 32'hFFFF_FFFF);
    chk("sat done", 32'(seq_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
